spi_pair_master: RTL and testbench

Synthesizable SPI master that transmits one three-word packet per request: a fixed 14-bit header word, then two 14-bit sample words (AD_1, AD_2). Each word goes MSB first in its own chip-select window. It is the initiator-side counterpart of the SPI slave in `top_all`. It generates `cs`, `sck` and `mosi` from the system clock, so a board-level or loopback build can drive the adaptive-filter core without an external host. It can optionally capture `miso` during each word.

---
 rtl/spi_pair_master.sv | 213 +++++++++++++++++++++
 tb/tb_spi_pair_master.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pair_master.sv
// spi_pair_master: SPI mode-0 master that sends HEADER, ad_1 and ad_2 as three
// MSB-first words, each in its own cs window. Define SPI_MISO_CAPTURE_EN to build miso capture.
module spi_pair_master #(
  parameter int                WORD_W   = 14,
  parameter logic [WORD_W-1:0] HEADER   = 14'h0FFF,
  parameter int                HALF_SCK = 820,
  parameter int                CS_SETUP = 1638,
  parameter int                CS_HOLD  = 1638,
  parameter int                CS_GAP   = 1638
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] ad_1,
  input  logic [WORD_W-1:0] ad_2,
  input  logic              miso,
  output logic              sck,
  output logic              mosi,
  output logic              cs,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rx_word,
  output logic              rx_valid,
  output logic [1:0]        rx_idx
);

  localparam int MAX_A = (HALF_SCK > CS_SETUP) ? HALF_SCK : CS_SETUP;
  localparam int MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  // Each phase loads (length - 1) and leaves when the counter reaches zero.
  localparam logic [CNT_W-1:0] LD_HALF  = CNT_W'(HALF_SCK - 1);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(CS_GAP - 1);
  localparam logic [3:0]       BIT_MSB  = 4'(WORD_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [3:0]        bit_idx, bit_d;
  logic [1:0]        word_idx, word_d;
  logic              accept;
  logic [WORD_W-1:0] ad1_q, ad2_q;
  logic [WORD_W-1:0] cur_word;
  logic              cs_d, sck_d, mosi_d, busy_d, done_d;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      word_idx <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_d;
      word_idx <= word_d;
    end
  end

  // NOTE: the sample latches need no reset; they are only read after a start has loaded them.
  always_ff @(posedge clk) begin
    if (accept) begin
      ad1_q <= ad_1;
      ad2_q <= ad_2;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    cnt_d   = (state == IDLE) ? cnt : cnt - CNT_W'(1);
    bit_d   = bit_idx;
    word_d  = word_idx;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SETUP;
          cnt_d   = LD_SETUP;
          bit_d   = BIT_MSB;
          word_d  = 2'd0;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_d = LOW;
          cnt_d   = LD_HALF;
        end
      end
      LOW: begin
        if (cnt == '0) begin
          state_d = HIGH;
          cnt_d   = LD_HALF;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          if (bit_idx == 4'd0) begin
            state_d = HOLD;
            cnt_d   = LD_HOLD;
          end else begin
            state_d = LOW;
            cnt_d   = LD_HALF;
            bit_d   = bit_idx - 4'd1;
          end
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_d = GAP;
          cnt_d   = LD_GAP;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if (word_idx == 2'd2) begin
            state_d = IDLE;
          end else begin
            state_d = SETUP;
            cnt_d   = LD_SETUP;
            bit_d   = BIT_MSB;
            word_d  = word_idx + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state.
  always_comb begin
    unique case (word_d)
      2'd0:    cur_word = HEADER;
      2'd1:    cur_word = ad1_q;
      default: cur_word = ad2_q;
    endcase
    cs_d   = 1'b1;
    sck_d  = 1'b0;
    mosi_d = 1'b0;
    busy_d = (state_d != IDLE);
    done_d = (state == GAP) && (state_d == IDLE);
    unique case (state_d)
      SETUP, LOW: begin
        cs_d   = 1'b0;
        mosi_d = cur_word[bit_d];
      end
      HIGH: begin
        cs_d   = 1'b0;
        sck_d  = 1'b1;
        mosi_d = mosi;
      end
      HOLD: begin
        cs_d   = 1'b0;
        mosi_d = mosi;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs   <= 1'b1;
      sck  <= 1'b0;
      mosi <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      cs   <= cs_d;
      sck  <= sck_d;
      mosi <= mosi_d;
      busy <= busy_d;
      done <= done_d;
    end
  end

`ifdef SPI_MISO_CAPTURE_EN
  logic [WORD_W-1:0] rx_sh;

  // miso is taken on the clk edge that raises sck; the word is published as cs rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sh    <= '0;
      rx_word  <= '0;
      rx_valid <= 1'b0;
      rx_idx   <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (state == LOW && state_d == HIGH) begin
        rx_sh <= {rx_sh[WORD_W-2:0], miso};
      end
      if (state == HOLD && state_d == GAP) begin
        rx_valid <= 1'b1;
        rx_word  <= rx_sh;
        rx_idx   <= word_idx;
      end
    end
  end
`else
  logic unused_miso;

  assign unused_miso = miso;
  assign rx_word     = '0;
  assign rx_valid    = 1'b0;
  assign rx_idx      = '0;
`endif

endmodule

// File: tb/tb_spi_pair_master.sv
// Directed bench for spi_pair_master with HALF_SCK=2 and CS_SETUP/HOLD/GAP=3 (word = 65 cycles).
module tb_spi_pair_master;

  logic        clk = 1'b0;
  logic        rst, start, miso;
  logic [13:0] ad_1, ad_2;
  logic        sck, mosi, cs, busy, done, rx_valid;
  logic [13:0] rx_word;
  logic [1:0]  rx_idx;

  spi_pair_master #(
    .WORD_W(14), .HEADER(14'h0FFF), .HALF_SCK(2),
    .CS_SETUP(3), .CS_HOLD(3), .CS_GAP(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ad_1(ad_1), .ad_2(ad_2), .miso(miso),
    .sck(sck), .mosi(mosi), .cs(cs), .busy(busy), .done(done),
    .rx_word(rx_word), .rx_valid(rx_valid), .rx_idx(rx_idx)
  );

  always #5 clk = ~clk;
  assign miso = mosi;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int t_acc    = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Independent observer: records cs edges, bits seen at sck rises, done and rx strobes.
  logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
  logic [13:0] sh = '0;
  int          rises = 0, unstable = 0;
  int          fall_q[$], rise_q[$], done_q[$], rises_q[$], rxv_q[$], rxi_q[$];
  logic [13:0] word_q[$], rxw_q[$];

  always @(negedge clk) begin
    if (prev_cs && !cs) begin
      fall_q.push_back(edge_cnt);
      rises = 0;
      sh    = '0;
    end
    if (!cs && sck && !prev_sck) begin
      sh = {sh[12:0], mosi};
      rises++;
      if (mosi !== prev_mosi) unstable++;
    end
    if (!prev_cs && cs) begin
      rise_q.push_back(edge_cnt);
      word_q.push_back(sh);
      rises_q.push_back(rises);
    end
    if (done) done_q.push_back(edge_cnt);
    if (rx_valid) begin
      rxv_q.push_back(edge_cnt);
      rxw_q.push_back(rx_word);
      rxi_q.push_back(int'(rx_idx));
    end
    prev_cs   = cs;
    prev_sck  = sck;
    prev_mosi = mosi;
  end

  typedef struct {
    int         rel;
    logic [4:0] exp;   // {cs, sck, mosi, busy, done}
  } vec_t;

  vec_t        vecs[19];
  logic [13:0] exp_w[3] = '{14'h0FFF, 14'h054B, 14'h054C};

  function automatic int rel();
    return edge_cnt - t_acc + 1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(string tag, logic [4:0] exp);
    check($sformatf("%s cyc%0d {cs,sck,mosi,busy,done}", tag, rel()),
          {27'd0, cs, sck, mosi, busy, done}, {27'd0, exp});
  endtask

  // Advance to a relative cycle; with iso set, corrupt ad_1 at 30 and pulse start at 40.
  task automatic step_to(int target, bit iso);
    for (int g = 0; g < 2000 && rel() < target; g++) begin
      @(negedge clk);
      if (iso) begin
        if (rel() == 30) ad_1 = 14'h3FFF;
        start = (rel() == 40);
      end
    end
  endtask

  task automatic clear_q();
    fall_q.delete(); rise_q.delete(); done_q.delete(); rises_q.delete();
    rxv_q.delete(); rxi_q.delete(); word_q.delete(); rxw_q.delete();
    unstable = 0;
  endtask

  task automatic accept(bit hold);
    start = 1'b1;
    @(negedge clk);
    start = hold;
    t_acc = edge_cnt;
  endtask

  task automatic check_packet(string tag);
    step_to(200, 1'b0);
    check({tag, " done count"}, done_q.size(), 1);
    check({tag, " done cycle"}, (done_q.size() > 0) ? done_q[0] - t_acc + 1 : -1, 196);
    check({tag, " cs windows"}, fall_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s cs fall %0d", tag, i),
            (i < fall_q.size()) ? fall_q[i] - t_acc + 1 : -1, 1 + 65 * i);
      check($sformatf("%s cs rise %0d", tag, i),
            (i < rise_q.size()) ? rise_q[i] - t_acc + 1 : -1, 63 + 65 * i);
      check($sformatf("%s word %0d", tag, i),
            (i < word_q.size()) ? 32'(word_q[i]) : 32'hFFFF_FFFF, 32'(exp_w[i]));
      check($sformatf("%s rises %0d", tag, i),
            (i < rises_q.size()) ? rises_q[i] : -1, 14);
    end
    check({tag, " mosi unstable at rise"}, unstable, 0);
`ifdef SPI_MISO_CAPTURE_EN
    check({tag, " rx count"}, rxv_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s rx cycle %0d", tag, i),
            (i < rxv_q.size()) ? rxv_q[i] - t_acc + 1 : -1, 63 + 65 * i);
      check($sformatf("%s rx word %0d", tag, i),
            (i < rxw_q.size()) ? 32'(rxw_q[i]) : 32'hFFFF_FFFF, 32'(exp_w[i]));
      check($sformatf("%s rx idx %0d", tag, i), (i < rxi_q.size()) ? rxi_q[i] : -1, i);
    end
`else
    check({tag, " rx strobes"}, rxv_q.size(), 0);
    check({tag, " rx word"}, 32'(rx_word), 0);
`endif
  endtask

  initial begin
    vecs[0]  = '{1,   5'b00010};
    vecs[1]  = '{3,   5'b00010};
    vecs[2]  = '{4,   5'b00010};
    vecs[3]  = '{6,   5'b01010};
    vecs[4]  = '{12,  5'b00110};
    vecs[5]  = '{59,  5'b01110};
    vecs[6]  = '{60,  5'b00110};
    vecs[7]  = '{62,  5'b00110};
    vecs[8]  = '{63,  5'b10010};
    vecs[9]  = '{65,  5'b10010};
    vecs[10] = '{66,  5'b00010};
    vecs[11] = '{81,  5'b00110};
    vecs[12] = '{181, 5'b01110};
    vecs[13] = '{186, 5'b00010};
    vecs[14] = '{192, 5'b00010};
    vecs[15] = '{193, 5'b10010};
    vecs[16] = '{195, 5'b10010};
    vecs[17] = '{196, 5'b10001};
    vecs[18] = '{197, 5'b10000};

    rst   = 1'b1;
    start = 1'b1;
    ad_1  = 14'h054B;
    ad_2  = 14'h054C;

    // Reset with start held high: nothing may begin while rst is asserted.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_outs($sformatf("reset%0d", i), 5'b10000);
      check($sformatf("reset%0d rx", i), {15'd0, rx_valid, rx_idx, rx_word}, 32'd0);
    end

    // Back-to-back: start stays high from reset release, so it is accepted on the next edge.
    rst = 1'b0;
    clear_q();
    @(negedge clk);
    t_acc = edge_cnt;
    check_outs("b2b accept", 5'b00010);
    step_to(196, 1'b0);
    check_outs("b2b done1", 5'b10001);
    step_to(197, 1'b0);
    check_outs("b2b restart", 5'b00010);
    step_to(300, 1'b0);
    start = 1'b0;
    step_to(392, 1'b0);
    check_outs("b2b done2", 5'b10001);
    step_to(393, 1'b0);
    check_outs("b2b idle", 5'b10000);
    check("b2b done count", done_q.size(), 2);
    check("b2b done2 cycle", (done_q.size() > 1) ? done_q[1] - t_acc + 1 : -1, 392);

    // Single packet with mid-packet ad_1 change and an ignored start pulse.
    step_to(420, 1'b0);
    clear_q();
    accept(1'b0);
    foreach (vecs[i]) begin
      step_to(vecs[i].rel, 1'b1);
      check_outs("single", vecs[i].exp);
    end
    check_packet("single");
    ad_1 = 14'h054B;

    // Reset mid-packet: immediate idle, no done, then a clean packet.
    step_to(260, 1'b0);
    clear_q();
    accept(1'b0);
    step_to(80, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_outs("rst mid", 5'b10000);
    check("rst mid rx_valid", {31'd0, rx_valid}, 32'd0);
    rst = 1'b0;
    step_to(400, 1'b0);
    check("rst mid no done", done_q.size(), 0);
    check_outs("rst mid idle", 5'b10000);
    clear_q();
    accept(1'b0);
    check_packet("after rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
